// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared types and sizes for the 2048x88 single-port SRAM request controller.
//   ADDR_WIDTH / DATA_WIDTH : SRAM geometry
//   DEPTH                   : number of SRAM entries
//   state_t                 : controller FSM state
package ct_f_spsram_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH = 11;
    localparam int unsigned DATA_WIDTH = 88;
    localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ct_f_spsram_2048x88_ctrl_if.sv
// Request/response handshake bundle between a requester and the SRAM controller.
//   req_vld/req_rdy      : request handshake
//   req_wr               : 1 = write, 0 = read
//   req_addr/wdata/wmask : request payload (wmask active-high per bit)
//   rsp_vld/rsp_rdy      : read-response handshake
//   rsp_rdata            : read data
// master = requester side, slave = controller side.
interface ct_f_spsram_2048x88_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = ct_f_spsram_ctrl_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = ct_f_spsram_ctrl_pkg::DATA_WIDTH
);

    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] req_wmask;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata
    );

endinterface

// File: rtl/ct_f_sram_rsp_fifo.sv
// Two-entry valid/ready FIFO buffering SRAM read data toward the consumer.
//   CLK, RST  : clock, synchronous active-high reset
//   push      : write push_data this cycle (caller guarantees space)
//   push_data : data to enqueue
//   pop       : consumer takes the head this cycle (ignored when empty)
//   out_vld   : head entry valid
//   out_data  : head entry data
//   cnt       : current occupancy, 0..2
module ct_f_sram_rsp_fifo #(
    parameter int unsigned DATA_WIDTH = ct_f_spsram_ctrl_pkg::DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            cnt
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            cnt_q;
    logic                  pop_take;

    assign pop_take = pop && (cnt_q != 2'd0);
    assign out_vld  = (cnt_q != 2'd0);
    assign out_data = mem_q[rd_ptr_q];
    assign cnt      = cnt_q;

    // Pointer and occupancy tracking; push and pop in one cycle are both taken.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_take) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + 2'(push) - 2'(pop_take);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(push && !pop_take && (cnt_q == 2'd2)));

    a_no_underflow: assert property (@(posedge CLK) disable iff (RST)
        !(pop && (cnt_q == 2'd0)));

endmodule

// File: rtl/ct_f_spsram_2048x88_ctrl.sv
// Request-side controller for the 2048x88 single-port SRAM.
// After reset it clears every entry to INIT_VALUE, then turns the valid/ready
// request stream into active-low CEN/GWEN/WEN pin activity and returns read
// data through a 2-entry response buffer.
//   CLK, RST       : clock (shared with SRAM), synchronous active-high reset
//   bus            : request/response handshake (slave side)
//   init_done      : high from the first cycle after the clear pass
//   A, CEN, GWEN,
//   WEN, D         : SRAM address, chip enable, global/bit write enables, data
//   Q              : SRAM read data, valid the cycle after a read issue
module ct_f_spsram_2048x88_ctrl #(
    parameter int unsigned            ADDR_WIDTH = ct_f_spsram_ctrl_pkg::ADDR_WIDTH,
    parameter int unsigned            DATA_WIDTH = ct_f_spsram_ctrl_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                      CLK,
    input  logic                      RST,
    ct_f_spsram_2048x88_ctrl_if.slave bus,
    output logic                      init_done,
    output logic [ADDR_WIDTH-1:0]     A,
    output logic                      CEN,
    output logic                      GWEN,
    output logic [DATA_WIDTH-1:0]     WEN,
    output logic [DATA_WIDTH-1:0]     D,
    input  logic [DATA_WIDTH-1:0]     Q
);

    import ct_f_spsram_ctrl_pkg::*;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic                  req_rdy_q;
    logic                  init_done_q;
    logic                  rd_inflight_q;
    logic                  accept_c;
    logic                  rd_accept_c;
    logic                  pop_c;
    logic                  init_last_c;
    logic                  req_rdy_d;
    logic [1:0]            buf_cnt;
    logic [2:0]            credit_c;

    assign init_last_c = &init_cnt_q;
    assign accept_c    = !RST && (state_q == RUN) && req_rdy_q && bus.req_vld;
    assign rd_accept_c = accept_c && !bus.req_wr;
    assign pop_c       = bus.rsp_vld && bus.rsp_rdy;

    // Reads still owed to the consumer after this cycle: buffered + in flight.
    assign credit_c  = 3'(buf_cnt) + 3'(rd_inflight_q) + 3'(rd_accept_c) - 3'(pop_c);
    assign req_rdy_d = (state_d == RUN) && (credit_c < 3'd2);

    assign bus.req_rdy = req_rdy_q;
    assign init_done   = init_done_q;

    // Next state and SRAM pin drive; A/D hold their last value when idle.
    always_comb begin
        state_d = state_q;
        A       = a_q;
        D       = d_q;
        CEN     = 1'b1;
        GWEN    = 1'b1;
        WEN     = '1;
        case (state_q)
            INIT: begin
                if (init_last_c) begin
                    state_d = RUN;
                end
                if (!RST) begin
                    A    = init_cnt_q;
                    D    = INIT_VALUE;
                    CEN  = 1'b0;
                    GWEN = 1'b0;
                    WEN  = '0;
                end
            end
            RUN: begin
                if (accept_c) begin
                    A    = bus.req_addr;
                    D    = bus.req_wdata;
                    CEN  = 1'b0;
                    GWEN = ~bus.req_wr;
                    WEN  = bus.req_wr ? ~bus.req_wmask : '1;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State, init counter, held pin values and handshake flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= INIT;
            init_cnt_q    <= '0;
            a_q           <= '0;
            d_q           <= '0;
            req_rdy_q     <= 1'b0;
            init_done_q   <= 1'b0;
            rd_inflight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            if ((state_q == INIT) && !init_last_c) begin
                init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
            end
            a_q           <= A;
            d_q           <= D;
            req_rdy_q     <= req_rdy_d;
            init_done_q   <= (state_d == RUN);
            rd_inflight_q <= rd_accept_c;
        end
    end

    // Q is only meaningful the cycle after a read issue, so push exactly then.
    ct_f_sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (rd_inflight_q),
        .push_data (Q),
        .pop       (pop_c),
        .out_vld   (bus.rsp_vld),
        .out_data  (bus.rsp_rdata),
        .cnt       (buf_cnt)
    );

endmodule

// File: tb/tb_ct_f_spsram_2048x88_ctrl.sv
// Self-checking bench for ct_f_spsram_2048x88_ctrl: behavioural SRAM, request-level
// scoreboard model, directed scenarios and randomized mixed traffic.
module tb_ct_f_spsram_2048x88_ctrl;

    import ct_f_spsram_ctrl_pkg::*;

    localparam logic [87:0] ONES = {88{1'b1}};

    logic  CLK = 1'b0;
    logic  RST;
    logic  init_done;
    addr_t A;
    logic  CEN;
    logic  GWEN;
    data_t WEN;
    data_t D;
    data_t Q;

    ct_f_spsram_2048x88_ctrl_if bus();

    ct_f_spsram_2048x88_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .init_done (init_done),
        .A         (A),
        .CEN       (CEN),
        .GWEN      (GWEN),
        .WEN       (WEN),
        .D         (D),
        .Q         (Q)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [87:0] act, input logic [87:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic data_t rnd_data();
        return data_t'({$urandom(), $urandom(), $urandom()});
    endfunction

    // Behavioural SRAM: Q is garbage except the cycle after a read.
    data_t sram [DEPTH];
    always @(posedge CLK) begin
        if (CEN === 1'b0) begin
            if (GWEN === 1'b0) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
            else               Q <= sram[A];
        end else begin
            Q <= rnd_data();
        end
        if (CEN === 1'b0 && GWEN === 1'b0) Q <= rnd_data();
    end

    // Request-level model: memory contents plus queue of owed responses with arrival cycle.
    typedef struct {
        data_t data;
        int    avail;
    } rsp_t;

    rsp_t  m_q[$];
    data_t m_mem [DEPTH];
    int    m_phase    = 0;
    int    m_idx      = 0;
    bit    m_rst_edge = 1'b0;
    bit    m_rdy      = 1'b0;
    addr_t m_a;
    data_t m_d;
    int    cyc        = 0;
    data_t popped[$];
    int    pop_cyc[$];

    always @(negedge CLK) begin
        bit vld_e;
        bit acc;
        cyc++;
        if (m_rst_edge) begin
            m_phase = 1;
            m_idx   = 0;
            m_q.delete();
            m_a     = '0;
            m_d     = '0;
            m_rdy   = 1'b0;
        end
        if (RST) begin
            if (m_rst_edge) begin
                chk("rst_req_rdy", 88'(bus.req_rdy), 88'(0));
                chk("rst_rsp_vld", 88'(bus.rsp_vld), 88'(0));
                chk("rst_init_done", 88'(init_done), 88'(0));
                chk("rst_cen", 88'(CEN), 88'(1));
                chk("rst_gwen", 88'(GWEN), 88'(1));
                chk("rst_wen", WEN, ONES);
                chk("rst_a", 88'(A), 88'(0));
                chk("rst_d", D, 88'(0));
            end
        end else if (m_phase == 1) begin
            chk("init_cen", 88'(CEN), 88'(0));
            chk("init_gwen", 88'(GWEN), 88'(0));
            chk("init_wen", WEN, 88'(0));
            chk("init_a", 88'(A), 88'(m_idx));
            chk("init_d", D, 88'(0));
            chk("init_req_rdy", 88'(bus.req_rdy), 88'(0));
            chk("init_rsp_vld", 88'(bus.rsp_vld), 88'(0));
            chk("init_done_lo", 88'(init_done), 88'(0));
            m_mem[m_idx] = '0;
            m_a = addr_t'(m_idx);
            m_d = '0;
            if (m_idx == DEPTH - 1) begin
                m_phase = 2;
                m_rdy   = 1'b1;
            end else begin
                m_idx++;
            end
        end else if (m_phase == 2) begin
            chk("run_init_done", 88'(init_done), 88'(1));
            chk("run_req_rdy", 88'(bus.req_rdy), 88'(m_rdy));
            vld_e = (m_q.size() > 0) && (m_q[0].avail <= cyc);
            chk("run_rsp_vld", 88'(bus.rsp_vld), 88'(vld_e));
            if (vld_e) chk("run_rsp_rdata", bus.rsp_rdata, m_q[0].data);
            acc = bus.req_vld && m_rdy;
            if (acc) begin
                m_a = bus.req_addr;
                m_d = bus.req_wdata;
                chk("pin_cen", 88'(CEN), 88'(0));
                chk("pin_gwen", 88'(GWEN), 88'(!bus.req_wr));
                chk("pin_wen", WEN, bus.req_wr ? ~bus.req_wmask : ONES);
            end else begin
                chk("idle_cen", 88'(CEN), 88'(1));
                chk("idle_gwen", 88'(GWEN), 88'(1));
                chk("idle_wen", WEN, ONES);
            end
            chk("pin_a", 88'(A), 88'(m_a));
            chk("pin_d", D, m_d);
            if (vld_e && bus.rsp_rdy) void'(m_q.pop_front());
            if (acc && bus.req_wr)
                m_mem[bus.req_addr] = (m_mem[bus.req_addr] & ~bus.req_wmask) |
                                      (bus.req_wdata & bus.req_wmask);
            if (acc && !bus.req_wr) m_q.push_back('{m_mem[bus.req_addr], cyc + 2});
            m_rdy = (m_q.size() < 2);
        end
        if (bus.rsp_vld && bus.rsp_rdy) begin
            popped.push_back(bus.rsp_rdata);
            pop_cyc.push_back(cyc);
        end
        m_rst_edge = RST;
    end

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_req(input logic wr, input addr_t addr, input data_t wd,
                          input data_t wm, output int acc_cyc);
        acc_cyc       = -1;
        bus.req_vld   = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_wmask = wm;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            #1;
            if (bus.req_rdy) acc_cyc = cyc;
            sync();
            if (acc_cyc >= 0) break;
        end
        bus.req_vld = 1'b0;
        chk("req_accept_timeout", 88'(acc_cyc >= 0), 88'(1));
    endtask

    task automatic wait_pops(input int n);
        for (int i = 0; i < 200; i++) begin
            if (popped.size() >= n) break;
            @(negedge CLK);
            #1;
        end
        chk("pop_wait", 88'(popped.size() >= n), 88'(1));
        sync();
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            #1;
            if (init_done) break;
            if (!CEN) n++;
        end
        chk("init_done_seen", 88'(init_done), 88'(1));
        chk("init_cycles", 88'(n), 88'(2048));
        chk("rdy_after_init", 88'(bus.req_rdy), 88'(1));
        chk("rsp_idle_after_init", 88'(bus.rsp_vld), 88'(0));
        sync();
    endtask

    initial begin
        int    a0;
        int    base;
        int    acc;
        int    n;
        int    guard;
        bit    hit;
        data_t wd [4];

        RST           = 1'b1;
        bus.req_vld   = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.rsp_rdy   = 1'b1;

        // Reset state, then full clear pass.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("lit_rst_rdy", 88'(bus.req_rdy), 88'(0));
        chk("lit_rst_cen", 88'(CEN), 88'(1));
        chk("lit_rst_done", 88'(init_done), 88'(0));
        sync();
        RST = 1'b0;
        wait_init();

        // Read of the last entry returns the cleared value two cycles after accept.
        base = popped.size();
        do_req(1'b0, 11'h7FF, '0, '0, a0);
        wait_pops(base + 1);
        chk("lit_rd_7ff", popped[base], 88'(0));
        chk("lit_rd_latency", 88'(pop_cyc[base] - a0), 88'(2));

        // Write, masked overwrite of the low byte, then read-after-write.
        base = popped.size();
        do_req(1'b1, 11'h123, 88'hA5A5A5A5A5A5A5A5A5A5A5, ONES, a0);
        do_req(1'b1, 11'h123, '0, 88'hFF, a0);
        do_req(1'b0, 11'h123, '0, '0, a0);
        wait_pops(base + 1);
        chk("lit_masked_rd", popped[base], 88'hA5A5A5A5A5A5A5A5A5A500);

        // Backpressure: only two reads accepted while the consumer stalls.
        for (int k = 0; k < 4; k++) begin
            wd[k] = {16'hC0DE, 64'h0, 8'(k)};
            do_req(1'b1, addr_t'(11'h10 + k), wd[k], ONES, a0);
        end
        base         = popped.size();
        bus.rsp_rdy  = 1'b0;
        acc          = 0;
        bus.req_vld  = 1'b1;
        bus.req_wr   = 1'b0;
        bus.req_addr = 11'h10;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            #1;
            hit = bus.req_vld && bus.req_rdy;
            sync();
            if (hit) begin
                acc++;
                bus.req_addr = addr_t'(11'h10 + acc);
            end
        end
        chk("lit_bp_accepts", 88'(acc), 88'(2));
        chk("lit_bp_rdy_low", 88'(bus.req_rdy), 88'(0));
        bus.rsp_rdy = 1'b1;
        for (int c = 0; c < 50 && acc < 4; c++) begin
            @(negedge CLK);
            #1;
            hit = bus.req_vld && bus.req_rdy;
            sync();
            if (hit) begin
                acc++;
                bus.req_addr = addr_t'(11'h10 + acc);
                if (acc == 4) bus.req_vld = 1'b0;
            end
        end
        bus.req_vld = 1'b0;
        chk("lit_bp_all_accepted", 88'(acc), 88'(4));
        wait_pops(base + 4);
        repeat (4) sync();
        chk("lit_bp_count", 88'(popped.size() - base), 88'(4));
        for (int k = 0; k < 4; k++) chk("lit_bp_order", popped[base + k], wd[k]);

        // Reset with two buffered responses.
        bus.rsp_rdy = 1'b0;
        do_req(1'b0, 11'h123, '0, '0, a0);
        do_req(1'b0, 11'h7FF, '0, '0, a0);
        repeat (3) sync();
        chk("lit_buf_full_vld", 88'(bus.rsp_vld), 88'(1));
        RST = 1'b1;
        sync();
        @(negedge CLK);
        #1;
        chk("lit_rst_flush_vld", 88'(bus.rsp_vld), 88'(0));
        chk("lit_rst_flush_a", 88'(A), 88'(0));
        sync();
        RST         = 1'b0;
        bus.rsp_rdy = 1'b1;
        base        = popped.size();
        wait_init();
        repeat (5) sync();
        chk("lit_no_stale", 88'(popped.size() - base), 88'(0));

        // Randomized mixed traffic against the model.
        n     = 0;
        guard = 0;
        while (n < 10000 && guard < 60000) begin
            guard++;
            if (!bus.req_vld && $urandom_range(9) < 8) begin
                bus.req_vld   = 1'b1;
                bus.req_wr    = 1'($urandom_range(1));
                bus.req_addr  = ($urandom_range(1) == 1) ? addr_t'($urandom_range(15))
                                                         : addr_t'($urandom_range(DEPTH - 1));
                bus.req_wdata = rnd_data();
                bus.req_wmask = ($urandom_range(1) == 1) ? ONES : rnd_data();
            end
            bus.rsp_rdy = (((n / 500) % 2) == 0) ? 1'b1 : 1'($urandom_range(3) != 0);
            @(negedge CLK);
            #1;
            hit = bus.req_vld && bus.req_rdy;
            sync();
            if (hit) begin
                n++;
                bus.req_vld = 1'b0;
            end
        end
        chk("rand_all_issued", 88'(n), 88'(10000));
        bus.req_vld = 1'b0;
        bus.rsp_rdy = 1'b1;
        repeat (10) sync();
        chk("rand_drained_vld", 88'(bus.rsp_vld), 88'(0));
        chk("rand_drained_rdy", 88'(bus.req_rdy), 88'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
